// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the layer sequencer and its argmax unit.
package nn_pkg;
   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned SCORE_W     = 8;
   localparam int unsigned DIGIT_W     = 4;

   localparam int unsigned L_FC1 = 0;
   localparam int unsigned L_FC2 = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LRST,
      S_LRUN,
      S_LNEXT,
      S_ARGMAX,
      S_DONE,
      S_ERR
   } state_e;
endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Signal bundle between the layer sequencer (master) and the engines/host around it (slave).
interface nn_layer_sequencer_if #(
   parameter int unsigned NUM_LAYERS  = 2,
   parameter int unsigned SEL_W       = 1,
   parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES
);
   logic                                   iStart;
   logic [NUM_LAYERS-1:0]                  iLayerDone;
   logic [NUM_LAYERS-1:0]                  iLayerOverflow;
   logic [NUM_CLASSES*nn_pkg::SCORE_W-1:0] iScores;
   logic [NUM_LAYERS-1:0]                  oLayerEna;
   logic [NUM_LAYERS-1:0]                  oLayerRst_n;
   logic [SEL_W-1:0]                       oSel;
   logic                                   oBusy;
   logic                                   oDone;
   logic                                   oOverflow;
   logic                                   oTimeout;
   logic [nn_pkg::DIGIT_W-1:0]             oDigit;

   modport master (
      input  iStart, iLayerDone, iLayerOverflow, iScores,
      output oLayerEna, oLayerRst_n, oSel, oBusy, oDone, oOverflow, oTimeout, oDigit
   );

   modport slave (
      output iStart, iLayerDone, iLayerOverflow, iScores,
      input  oLayerEna, oLayerRst_n, oSel, oBusy, oDone, oOverflow, oTimeout, oDigit
   );
endinterface

// File: rtl/seq_argmax.sv
// Serial max-finder: one unsigned score per cycle, strict compare so ties keep the lowest index.
module seq_argmax #(
   parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES
) (
   input  logic                                   clk,
   input  logic                                   iRst_n,
   input  logic                                   start,
   input  logic [NUM_CLASSES*nn_pkg::SCORE_W-1:0] scores,
   output logic                                   done,
   output logic [nn_pkg::DIGIT_W-1:0]             idx
);
   import nn_pkg::*;

   logic               run_q;
   logic [DIGIT_W-1:0] k_q;
   logic [SCORE_W-1:0] best_q;
   logic [DIGIT_W-1:0] idx_q;
   logic [SCORE_W-1:0] score_k;
   logic               take;

   assign score_k = scores[k_q*SCORE_W +: SCORE_W];
   assign take    = run_q && (score_k > best_q);
   assign done    = run_q && (k_q == DIGIT_W'(NUM_CLASSES - 1));
   // Includes the class being compared this cycle so the result is final when done is high.
   assign idx     = take ? k_q : idx_q;

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         run_q  <= 1'b0;
         k_q    <= '0;
         best_q <= '0;
         idx_q  <= '0;
      end else if (start) begin
         run_q  <= 1'b1;
         k_q    <= '0;
         best_q <= '0;
         idx_q  <= '0;
      end else if (run_q) begin
         if (take) begin
            best_q <= score_k;
            idx_q  <= k_q;
         end
         if (done) begin
            run_q <= 1'b0;
         end else begin
            k_q <= k_q + DIGIT_W'(1);
         end
      end
   end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs the layer engines one at a time over the shared MultAdder/ROM, then reports the argmax digit.
module nn_layer_sequencer #(
   parameter int unsigned NUM_LAYERS     = 2,
   parameter int unsigned SEL_W          = 1,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned NUM_CLASSES    = nn_pkg::NUM_CLASSES
) (
   input logic                  clk,
   input logic                  iRst_n,
   nn_layer_sequencer_if.master bus
);
   import nn_pkg::*;

   localparam int unsigned MAX_CNT = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
   localparam logic [SEL_W-1:0] LAST_L = SEL_W'(NUM_LAYERS - 1);

   function automatic logic [NUM_LAYERS-1:0] layer_bit(input logic [SEL_W-1:0] l);
      return NUM_LAYERS'(1) << l;
   endfunction

   state_e                  state_q;
   logic [SEL_W-1:0]        layer_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [NUM_LAYERS-1:0]   ena_q;
   logic [NUM_LAYERS-1:0]   rst_n_q;
   logic [SEL_W-1:0]        sel_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    ovf_q;
   logic                    tmo_q;
   logic [DIGIT_W-1:0]      digit_q;

   logic                    arg_start;
   logic                    arg_done;
   logic [DIGIT_W-1:0]      arg_idx;

   // Argmax starts on the edge that leaves LNEXT, so ARGMAX lasts exactly NUM_CLASSES cycles.
   assign arg_start = (state_q == S_LNEXT) && (layer_q == LAST_L);

   seq_argmax #(
      .NUM_CLASSES(NUM_CLASSES)
   ) u_argmax (
      .clk   (clk),
      .iRst_n(iRst_n),
      .start (arg_start),
      .scores(bus.iScores),
      .done  (arg_done),
      .idx   (arg_idx)
   );

   always_ff @(posedge clk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         cnt_q   <= '0;
         ena_q   <= '0;
         rst_n_q <= '1;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         digit_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.iStart) begin
                  state_q <= S_LRST;
                  layer_q <= '0;
                  cnt_q   <= '0;
                  sel_q   <= '0;
                  ena_q   <= layer_bit('0);
                  rst_n_q <= ~layer_bit('0);
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  tmo_q   <= 1'b0;
                  digit_q <= '0;
               end
            end
            S_LRST: begin
               if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                  state_q <= S_LRUN;
                  cnt_q   <= '0;
                  rst_n_q <= '1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_LRUN: begin
               // Only the selected layer's flags matter; the others may float while disabled.
               if (bus.iLayerDone[layer_q]) begin
                  state_q <= S_LNEXT;
                  ovf_q   <= ovf_q | bus.iLayerOverflow[layer_q];
                  ena_q   <= '0;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                  state_q <= S_ERR;
                  ena_q   <= '0;
                  busy_q  <= 1'b0;
                  tmo_q   <= 1'b1;
                  digit_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_LNEXT: begin
               if (layer_q == LAST_L) begin
                  state_q <= S_ARGMAX;
               end else begin
                  state_q <= S_LRST;
                  layer_q <= layer_q + SEL_W'(1);
                  sel_q   <= layer_q + SEL_W'(1);
                  ena_q   <= layer_bit(layer_q + SEL_W'(1));
                  rst_n_q <= ~layer_bit(layer_q + SEL_W'(1));
                  cnt_q   <= '0;
               end
            end
            S_ARGMAX: begin
               if (arg_done) begin
                  state_q <= S_DONE;
                  digit_q <= arg_idx;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.oLayerEna   = ena_q;
   assign bus.oLayerRst_n = rst_n_q;
   assign bus.oSel        = sel_q;
   assign bus.oBusy       = busy_q;
   assign bus.oDone       = done_q;
   assign bus.oOverflow   = ovf_q;
   assign bus.oTimeout    = tmo_q;
   assign bus.oDigit      = digit_q;
endmodule
